// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: shares the sample_counter register-write port between
// buffered host writes (port A) and a req/grant sequencer (port B).
// Round-robin arbitration with a host-priority override when the FIFO is
// nearly full, and a programmable idle gap after each issued write.
module reg_write_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16
) (
  input  logic                          clk_in,
  input  logic                          reset_in,
  input  logic [DATA_W-1:0]             a_data_in,
  input  logic [ADDR_W-1:0]             a_addr_in,
  input  logic                          a_valid_in,
  input  logic [DATA_W-1:0]             b_data_in,
  input  logic [ADDR_W-1:0]             b_addr_in,
  input  logic                          b_req_in,
  output logic                          b_grant_out,
  output logic [DATA_W-1:0]             data_out,
  output logic [ADDR_W-1:0]             addr_out,
  output logic                          data_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
  output logic                          overflow_out,
  input  logic                          ovf_clr_in
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t             state;
  logic [GAP_W-1:0]   gap_cnt;
  logic               last_src_b;
  logic [ENT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENT_W-1:0]   head;

  logic a_pend, b_pend, pick_ok, pick_a, pick_b, pop, push, drop;

  // Arbitration: decisions use the registered level. The grant cycle masks
  // b_req_in because the requester is still holding the request just served.
  // A decision may also be taken in the last gap cycle (or in ISSUE when
  // there is no gap) so the forced idle spacing is exactly GAP_CYCLES.
  always_comb begin
    head    = mem[rd_ptr];
    a_pend  = (fifo_level_out != '0);
    b_pend  = b_req_in && !b_grant_out;
    pick_ok = (state == IDLE) ||
              ((state == GAP) && (gap_cnt == GAP_W'(1))) ||
              ((state == ISSUE) && (GAP_CYCLES == 0));
    pick_a  = a_pend && (!b_pend || last_src_b ||
                         (fifo_level_out >= LVL_W'(FIFO_DEPTH - 1)));
    pick_b  = b_pend && !pick_a;
    pop     = pick_ok && pick_a;
    push    = a_valid_in && ((fifo_level_out < LVL_W'(FIFO_DEPTH)) || pop);
    drop    = a_valid_in && !push;
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= {a_addr_in, a_data_in};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level_out <= fifo_level_out + LVL_W'(1);
        2'b01:   fifo_level_out <= fifo_level_out - LVL_W'(1);
        default: fifo_level_out <= fifo_level_out;
      endcase
    end
  end

  // Sticky overflow flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk_in) begin
    if (reset_in)        overflow_out <= 1'b0;
    else if (drop)       overflow_out <= 1'b1;
    else if (ovf_clr_in) overflow_out <= 1'b0;
  end

  // Issue FSM with registered write-port outputs.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state          <= IDLE;
      gap_cnt        <= '0;
      last_src_b     <= 1'b1;
      data_valid_out <= 1'b0;
      b_grant_out    <= 1'b0;
      data_out       <= '0;
      addr_out       <= '0;
    end else begin
      data_valid_out <= 1'b0;
      b_grant_out    <= 1'b0;
      case (state)
        IDLE: state <= IDLE;
        ISSUE: begin
          if (GAP_CYCLES > 0) begin
            state   <= GAP;
            gap_cnt <= GAP_W'(GAP_CYCLES);
          end else begin
            state <= IDLE;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (pick_ok && (pick_a || pick_b)) begin
        state          <= ISSUE;
        data_valid_out <= 1'b1;
        b_grant_out    <= pick_b;
        last_src_b     <= pick_b;
        if (pick_a) {addr_out, data_out} <= head;
        else        {addr_out, data_out} <= {b_addr_in, b_data_in};
      end
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a vector table on a GAP_CYCLES=1
// instance plus hand sequences on a GAP_CYCLES=3 instance.
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        av, br, clr;
  logic [3:0]  aa, ba;
  logic [15:0] ad, bd;

  logic        g1, v1, o1;
  logic [15:0] d1;
  logic [3:0]  a1;
  logic [2:0]  l1;
  logic        g3, v3, o3;
  logic [15:0] d3;
  logic [3:0]  a3;
  logic [2:0]  l3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.FIFO_DEPTH(4), .GAP_CYCLES(1), .ADDR_W(4), .DATA_W(16)) dut (
    .clk_in(clk), .reset_in(rst),
    .a_data_in(ad), .a_addr_in(aa), .a_valid_in(av),
    .b_data_in(bd), .b_addr_in(ba), .b_req_in(br),
    .b_grant_out(g1), .data_out(d1), .addr_out(a1), .data_valid_out(v1),
    .fifo_level_out(l1), .overflow_out(o1), .ovf_clr_in(clr));

  reg_write_arbiter #(.FIFO_DEPTH(4), .GAP_CYCLES(3), .ADDR_W(4), .DATA_W(16)) dut3 (
    .clk_in(clk), .reset_in(rst),
    .a_data_in(ad), .a_addr_in(aa), .a_valid_in(av),
    .b_data_in(bd), .b_addr_in(ba), .b_req_in(br),
    .b_grant_out(g3), .data_out(d3), .addr_out(a3), .data_valid_out(v3),
    .fifo_level_out(l3), .overflow_out(o3), .ovf_clr_in(clr));

  typedef struct {
    logic        rst;
    logic        av;
    logic [3:0]  aa;
    logic [15:0] ad;
    logic        br;
    logic [3:0]  ba;
    logic [15:0] bd;
    logic        ev;
    logic [3:0]  ea;
    logic [15:0] ed;
    logic        eg;
    logic [2:0]  el;
    logic        eo;
  } vec_t;

  localparam int NV = 23;
  vec_t vt[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; av = 1'b0; br = 1'b0; clr = 1'b0;
    aa = '0; ad = '0; ba = '0; bd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic vec_t mk(logic r, logic iav, logic [3:0] iaa, logic [15:0] iad,
                              logic ibr, logic [3:0] iba, logic [15:0] ibd,
                              logic ev, logic [3:0] ea, logic [15:0] ed,
                              logic eg, logic [2:0] el);
    vec_t v;
    v.rst = r; v.av = iav; v.aa = iaa; v.ad = iad;
    v.br = ibr; v.ba = iba; v.bd = ibd;
    v.ev = ev; v.ea = ea; v.ed = ed; v.eg = eg; v.el = el; v.eo = 1'b0;
    return v;
  endfunction

  int issued;
  int obs, k;
  logic ev;

  initial begin
    // row inputs apply during one cycle; expectations are the outputs after that edge
    vt[0]  = mk(0, 1, 4'd3, 16'h1234, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 3'd1);
    vt[1]  = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd3, 16'h1234, 0, 3'd0);
    vt[2]  = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd3, 16'h1234, 0, 3'd0);
    vt[3]  = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd3, 16'h1234, 0, 3'd0);
    vt[4]  = mk(1, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 3'd0);
    vt[5]  = mk(0, 1, 4'd1, 16'hAAAA, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 3'd1);
    vt[6]  = mk(0, 0, 4'd0, 16'h0000, 1, 4'd2, 16'h5555, 1, 4'd1, 16'hAAAA, 0, 3'd0);
    vt[7]  = mk(0, 0, 4'd0, 16'h0000, 1, 4'd2, 16'h5555, 0, 4'd1, 16'hAAAA, 0, 3'd0);
    vt[8]  = mk(0, 0, 4'd0, 16'h0000, 1, 4'd2, 16'h5555, 1, 4'd2, 16'h5555, 1, 3'd0);
    vt[9]  = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd2, 16'h5555, 0, 3'd0);
    vt[10] = mk(0, 1, 4'd4, 16'h0404, 0, 4'd0, 16'h0000, 0, 4'd2, 16'h5555, 0, 3'd1);
    vt[11] = mk(0, 1, 4'd5, 16'h0505, 0, 4'd0, 16'h0000, 1, 4'd4, 16'h0404, 0, 3'd1);
    vt[12] = mk(0, 1, 4'd6, 16'h0606, 0, 4'd0, 16'h0000, 0, 4'd4, 16'h0404, 0, 3'd2);
    vt[13] = mk(0, 1, 4'd7, 16'h0707, 0, 4'd0, 16'h0000, 1, 4'd5, 16'h0505, 0, 3'd2);
    vt[14] = mk(0, 1, 4'd8, 16'h0808, 1, 4'd9, 16'h9999, 0, 4'd5, 16'h0505, 0, 3'd3);
    vt[15] = mk(0, 0, 4'd0, 16'h0000, 1, 4'd9, 16'h9999, 1, 4'd6, 16'h0606, 0, 3'd2);
    vt[16] = mk(0, 0, 4'd0, 16'h0000, 1, 4'd9, 16'h9999, 0, 4'd6, 16'h0606, 0, 3'd2);
    vt[17] = mk(0, 0, 4'd0, 16'h0000, 1, 4'd9, 16'h9999, 1, 4'd9, 16'h9999, 1, 3'd2);
    vt[18] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd9, 16'h9999, 0, 3'd2);
    vt[19] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd7, 16'h0707, 0, 3'd1);
    vt[20] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd7, 16'h0707, 0, 3'd1);
    vt[21] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 1, 4'd8, 16'h0808, 0, 3'd0);
    vt[22] = mk(0, 0, 4'd0, 16'h0000, 0, 4'd0, 16'h0000, 0, 4'd8, 16'h0808, 0, 3'd0);

    // reset state
    do_reset();
    chk("rst_valid", {31'd0, v1}, 32'd0);
    chk("rst_grant", {31'd0, g1}, 32'd0);
    chk("rst_data",  {16'd0, d1}, 32'd0);
    chk("rst_addr",  {28'd0, a1}, 32'd0);
    chk("rst_level", {29'd0, l1}, 32'd0);
    chk("rst_ovf",   {31'd0, o1}, 32'd0);

    // latency, round-robin, and near-full host priority
    for (int i = 0; i < NV; i++) begin
      rst = vt[i].rst; av = vt[i].av; aa = vt[i].aa; ad = vt[i].ad;
      br = vt[i].br; ba = vt[i].ba; bd = vt[i].bd; clr = 1'b0;
      tick();
      chk($sformatf("vec%0d_valid", i), {31'd0, v1}, {31'd0, vt[i].ev});
      chk($sformatf("vec%0d_grant", i), {31'd0, g1}, {31'd0, vt[i].eg});
      chk($sformatf("vec%0d_addr", i),  {28'd0, a1}, {28'd0, vt[i].ea});
      chk($sformatf("vec%0d_data", i),  {16'd0, d1}, {16'd0, vt[i].ed});
      chk($sformatf("vec%0d_level", i), {29'd0, l1}, {29'd0, vt[i].el});
      chk($sformatf("vec%0d_ovf", i),   {31'd0, o1}, {31'd0, vt[i].eo});
    end
    idle_inputs();

    // GAP=3: seven back-to-back host writes, 7th dropped together with a clear
    do_reset();
    issued = 0;
    for (int c = 0; c < 26; c++) begin
      av  = (c <= 6);
      aa  = 4'(c + 1);
      ad  = 16'hC000 + 16'(c);
      clr = (c == 6);
      tick();
      obs = c + 1;
      k   = (obs - 2) / 4;
      ev  = (obs >= 2) && ((obs - 2) % 4 == 0) && (k < 6);
      chk($sformatf("g3_valid_c%0d", obs), {31'd0, v3}, {31'd0, ev});
      if (v3) issued++;
      if (ev) begin
        chk($sformatf("g3_addr_c%0d", obs), {28'd0, a3}, 32'(k + 1));
        chk($sformatf("g3_data_c%0d", obs), {16'd0, d3}, 32'h0000C000 + 32'(k));
      end
      chk($sformatf("g3_ovf_c%0d", obs), {31'd0, o3}, {31'd0, (obs >= 7)});
      chk($sformatf("g3_lvlmax_c%0d", obs), {31'd0, (l3 <= 3'd4)}, 32'd1);
      chk($sformatf("g3_grant_c%0d", obs), {31'd0, g3}, 32'd0);
    end
    idle_inputs();
    chk("g3_issued", 32'(issued), 32'd6);

    // a lone clear now takes effect
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ovf_lone_clr", {31'd0, o3}, 32'd0);

    // reset while three host writes are queued and a B request is pending
    do_reset();
    for (int c = 0; c < 4; c++) begin
      av = 1'b1; aa = 4'(c + 10); ad = 16'hD000 + 16'(c);
      br = (c == 3); ba = 4'hF; bd = 16'hBEEF;
      tick();
    end
    chk("flush_pre_level", {29'd0, l3}, 32'd3);
    av = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; br = 1'b0;
    chk("flush_level", {29'd0, l3}, 32'd0);
    chk("flush_ovf",   {31'd0, o3}, 32'd0);
    chk("flush_valid", {31'd0, v3}, 32'd0);
    chk("flush_level1", {29'd0, l1}, 32'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("flush_quiet3_%0d", c), {30'd0, v3, g3}, 32'd0);
      chk($sformatf("flush_quiet1_%0d", c), {30'd0, v1, g1}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
